pp_mac_scheduler: RTL and testbench



---
 rtl/pp_mac_scheduler.sv | 137 +++++++++++++
 tb/tb_pp_mac_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_mac_scheduler.sv
// Log-domain multiply-accumulate sequencer: one tap beat per cycle through a shared
// partial-product register, one saturated window sum per output handshake. Macro PPS_RELU_EN clamps negative results to zero.
module pp_mac_scheduler #(
    parameter int ACC_W    = 32,
    parameter int MAX_TAPS = 9,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_image,
    input  logic [3:0]       s_weight,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic [CNT_W-1:0] m_count,
    output logic             m_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               pp_valid_q, pp_valid_d;
    logic               pp_sign_q, pp_sign_d;
    logic [24:0]        pp_mag_q, pp_mag_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;

    logic               accept;
    logic               zero;
    logic [4:0]         shift;
    logic [24:0]        base;
    logic [CNT_W-1:0]   count_next;
    logic               last_beat;
    logic [ACC_W:0]     acc_ext, mag_ext, sum;

    assign s_ready = s_ready_q & rst;
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        pp_valid_d = accept;
        pp_sign_d  = pp_sign_q;
        pp_mag_d   = pp_mag_q;

        zero       = (s_image[6:0] == 7'd0) | (s_weight[2:0] == 3'b111);
        shift      = {1'b0, s_image[6:3]} + {2'b00, s_weight[2:0]};
        base       = {21'd0, 1'b1, s_image[2:0]};
        count_next = count_q + 1'b1;
        last_beat  = s_last | (count_next == CNT_W'(MAX_TAPS));

        if (accept) begin
            pp_sign_d = s_image[7] ^ s_weight[3];
            pp_mag_d  = zero ? 25'd0 : (base << shift);
        end

        // One extra bit of headroom: the top two bits disagree exactly when the add overflowed
        acc_ext = {acc_q[ACC_W-1], acc_q};
        mag_ext = (ACC_W+1)'(pp_mag_q);
        sum     = pp_sign_q ? (acc_ext - mag_ext) : (acc_ext + mag_ext);
        if (pp_valid_q) begin
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    count_d = count_next;
                    state_d = last_beat ? DRAIN : ACCUM;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == IDLE) || (state_d == ACCUM);
        m_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            pp_valid_q <= 1'b0;
            pp_sign_q  <= 1'b0;
            pp_mag_q   <= '0;
            s_ready_q  <= 1'b1;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            pp_valid_q <= pp_valid_d;
            pp_sign_q  <= pp_sign_d;
            pp_mag_q   <= pp_mag_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_count = m_valid_q ? count_q : '0;
    assign m_ovf   = m_valid_q & ovf_q;
`ifdef PPS_RELU_EN
    assign m_data  = (m_valid_q && !acc_q[ACC_W-1]) ? acc_q : '0;
`else
    assign m_data  = m_valid_q ? acc_q : '0;
`endif

endmodule

// File: tb/tb_pp_mac_scheduler.sv
// Self-checking bench for pp_mac_scheduler: a 32-bit and a 26-bit accumulator instance
// share one stimulus stream and are checked against an arithmetic window model.
module tb_pp_mac_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic s_valid = 1'b0;
   logic s_last = 1'b0;
   logic m_ready = 1'b0;
   logic [7:0] s_image = 8'h00;
   logic [3:0] s_weight = 4'h0;

   logic s_ready_a, s_ready_b, m_valid_a, m_valid_b, ovf_a, ovf_b;
   logic signed [31:0] m_data_a;
   logic signed [25:0] m_data_b;
   logic [3:0] count_a, count_b;

   int tests = 0;
   int fails = 0;

   longint accModelA, accModelB;
   bit ovfModelA, ovfModelB, closedModel;
   int cntModel;

   typedef struct {
      logic [7:0] img;
      logic [3:0] wt;
      longint data;
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;

   pp_mac_scheduler #(.ACC_W(32), .MAX_TAPS(9), .CNT_W(4)) u_dut32 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a),
      .s_image(s_image), .s_weight(s_weight), .s_last(s_last),
      .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
      .m_count(count_a), .m_ovf(ovf_a));

   pp_mac_scheduler #(.ACC_W(26), .MAX_TAPS(9), .CNT_W(4)) u_dut26 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b),
      .s_image(s_image), .s_weight(s_weight), .s_last(s_last),
      .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
      .m_count(count_b), .m_ovf(ovf_b));

   // Single comparison point so every check is counted and reported the same way
   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Signed value of one tap: (1.mantissa) scaled by 2^(exponent sum), zero-coded taps give 0
   function automatic longint beatValue(input logic [7:0] img, input logic [3:0] wt);
      int ex;
      longint mag;
      if (img[6:0] == 7'd0 || wt[2:0] == 3'b111) return 0;
      ex = int'(img[6:3]) + int'(wt[2:0]);
      mag = longint'(8 + int'(img[2:0])) * (longint'(1) << ex);
      return (img[7] ^ wt[3]) ? -mag : mag;
   endfunction

   function automatic longint clampTo(input longint v, input int w);
      longint hi, lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint expData(input longint a);
`ifdef PPS_RELU_EN
      return (a < 0) ? 0 : a;
`else
      return a;
`endif
   endfunction

   task automatic resetModel();
      accModelA = 0;
      accModelB = 0;
      ovfModelA = 0;
      ovfModelB = 0;
      cntModel = 0;
      closedModel = 0;
   endtask

   task automatic modelBeat(input logic [7:0] img, input logic [3:0] wt, input bit last);
      longint v, s;
      v = beatValue(img, wt);
      s = accModelA + v;
      if (clampTo(s, 32) != s) ovfModelA = 1;
      accModelA = clampTo(s, 32);
      s = accModelB + v;
      if (clampTo(s, 26) != s) ovfModelB = 1;
      accModelB = clampTo(s, 26);
      cntModel++;
      if (last || cntModel == 9) closedModel = 1;
   endtask

   // Present one beat after an optional idle gap and hold it until it is taken
   task automatic applyStimulus(input logic [7:0] img, input logic [3:0] wt, input bit last,
                                input int gap);
      int waited;
      repeat (gap) tick();
      s_valid = 1'b1;
      s_image = img;
      s_weight = wt;
      s_last = last;
      waited = 0;
      while (!s_ready_a && waited < 20) begin
         tick();
         waited++;
      end
      if (!s_ready_a) begin
         check("beat_accept_timeout", 0, 1);
      end else begin
         tick();
         modelBeat(img, wt, last);
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   // Called right after the closing beat's edge: checks drain, result, hold and release
   task automatic checkOutput(input string name, input int hold, input bit useExp,
                              input longint expVal);
      check({name, " drain_s_ready"}, longint'(s_ready_a), 0);
      check({name, " drain_m_valid"}, longint'(m_valid_a), 0);
      tick();
      check({name, " m_valid32"}, longint'(m_valid_a), 1);
      check({name, " m_valid26"}, longint'(m_valid_b), 1);
      check({name, " out_s_ready"}, longint'(s_ready_b), 0);
      check({name, " m_data32"}, m_data_a, expData(accModelA));
      check({name, " m_data26"}, m_data_b, expData(accModelB));
      if (useExp) check({name, " m_data_table"}, m_data_a, expData(expVal));
      check({name, " m_count32"}, longint'(count_a), longint'(cntModel));
      check({name, " m_count26"}, longint'(count_b), longint'(cntModel));
      check({name, " m_ovf32"}, longint'(ovf_a), longint'(ovfModelA));
      check({name, " m_ovf26"}, longint'(ovf_b), longint'(ovfModelB));
      m_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({name, " hold_m_valid"}, longint'(m_valid_a), 1);
         check({name, " hold_m_data"}, m_data_a, expData(accModelA));
         check({name, " hold_m_count"}, longint'(count_a), longint'(cntModel));
         check({name, " hold_s_ready"}, longint'(s_ready_a), 0);
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check({name, " release_m_valid"}, longint'(m_valid_a), 0);
      check({name, " release_s_ready"}, longint'(s_ready_a), 1);
      resetModel();
   endtask

   task automatic checkAllZero(input string name);
      check({name, " m_valid"}, longint'(m_valid_a), 0);
      check({name, " m_data"}, m_data_a, 0);
      check({name, " m_count"}, longint'(count_a), 0);
      check({name, " m_ovf"}, longint'(ovf_a), 0);
      check({name, " s_ready"}, longint'(s_ready_a), 0);
   endtask

   initial begin
      int n;
      resetModel();

      vecs[0] = '{8'h1A, 4'h2, 320};
      vecs[1] = '{8'h9A, 4'h2, -320};
      vecs[2] = '{8'h1A, 4'h7, 0};
      vecs[3] = '{8'h80, 4'h2, 0};
      vecs[4] = '{8'h08, 4'h0, 16};
      vecs[5] = '{8'h7F, 4'h6, 31457280};
      vecs[6] = '{8'hFF, 4'h6, -31457280};
      vecs[7] = '{8'h01, 4'h0, 9};
      vecs[8] = '{8'h0F, 4'hD, -960};

      rst = 1'b0;
      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b1;
      tick();
      check("reset_release s_ready", longint'(s_ready_a), 1);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].img, vecs[i].wt, 1'b1, 0);
         checkOutput($sformatf("vec%0d", i), 0, 1'b1, vecs[i].data);
      end

      applyStimulus(8'h1A, 4'h2, 1'b0, 0);
      applyStimulus(8'h9A, 4'h2, 1'b0, 0);
      applyStimulus(8'h1A, 4'h7, 1'b1, 0);
      checkOutput("three_cancel", 5, 1'b1, 0);
      applyStimulus(8'h80, 4'h2, 1'b0, 0);
      applyStimulus(8'h9A, 4'h2, 1'b0, 1);
      applyStimulus(8'h1A, 4'h7, 1'b1, 2);
      checkOutput("three_neg", 0, 1'b1, -320);

      for (int i = 0; i < 9; i++) applyStimulus(8'h08, 4'h0, 1'b0, 0);
      checkOutput("max_taps", 0, 1'b1, 144);

      applyStimulus(8'h7F, 4'h6, 1'b0, 0);
      applyStimulus(8'h7F, 4'h6, 1'b1, 0);
      check("sat model26 ovf", longint'(ovfModelB), 1);
      checkOutput("saturate", 0, 1'b1, 62914560);
      applyStimulus(8'h08, 4'h0, 1'b1, 0);
      checkOutput("after_sat", 0, 1'b1, 16);

      applyStimulus(8'h1A, 4'h2, 1'b0, 0);
      applyStimulus(8'h1A, 4'h2, 1'b0, 0);
      rst = 1'b0;
      #1;
      check("mid_reset s_ready", longint'(s_ready_a), 0);
      tick();
      checkAllZero("mid_reset");
      rst = 1'b1;
      resetModel();
      tick();
      applyStimulus(8'h1A, 4'h2, 1'b1, 0);
      checkOutput("post_reset", 0, 1'b1, 320);
      applyStimulus(8'h9A, 4'h2, 1'b1, 0);
      checkOutput("post_reset_neg", 0, 1'b1, -320);

      for (int w = 0; w < 40; w++) begin
         n = 0;
         while (!closedModel && n < 12) begin
            applyStimulus(8'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 2)));
            n++;
         end
         checkOutput($sformatf("rand%0d", w), int'($urandom_range(0, 3)), 1'b0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
